// File: rtl/plb_arbiter.sv
// plb_arbiter: round-robin arbiter giving three requesters burst access
// (1..4 words) to a single BRAM port. Writes stream one word per cycle.
// Reads return each word two cycles after its beat, tagged with the owner's index.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | no grant; pick the next requester round-robin
//   BURST   | one beat per cycle on the BRAM port for the granted owner
//   RD_WAIT | read beats finished; hold the grant while data drains
module plb_arbiter #(
    parameter int RSA_DW = 32,
    parameter int ADDR_W = 10
) (
    input  logic                  clk,
    input  logic                  sys_rst_n,
    input  logic [2:0]            rq_req,
    input  logic [2:0]            rq_we,
    input  logic [3*ADDR_W-1:0]   rq_addr,
    input  logic [5:0]            rq_len,
    input  logic [3*RSA_DW-1:0]   rq_wdata,
    output logic [2:0]            rq_gnt,
    output logic [2:0]            rq_wr_adv,
    output logic [2:0]            rq_done,
    output logic                  rd_valid,
    output logic [RSA_DW-1:0]     rd_data,
    output logic [1:0]            rd_id,
    output logic                  PLB_en,
    output logic                  PLB_we,
    output logic [ADDR_W-1:0]     PLB_addr,
    output logic [RSA_DW-1:0]     PLB_din,
    input  logic [RSA_DW-1:0]     PLB_dout,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BURST   = 2'd1,
        RD_WAIT = 2'd2
    } state_t;

    state_t            state;
    logic [1:0]        owner;
    logic [1:0]        last_gnt;
    logic [1:0]        remain;
    logic              wait_cnt;
    logic              bw;
    logic [ADDR_W-1:0] cur_addr;
    logic [2:0]        gnt_q;

    logic              rd_pend;
    logic [1:0]        rd_pend_id;

    logic [ADDR_W-1:0] addr_v  [3];
    logic [1:0]        len_v   [3];
    logic [RSA_DW-1:0] wdata_v [3];

    logic              win_found;
    logic [1:0]        win_idx;
    logic [1:0]        cand;

    logic              beat;
    logic              wr_beat;
    logic              rd_beat;

    // Split the flat per-requester buses into indexable arrays.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            addr_v[i]  = rq_addr[i*ADDR_W +: ADDR_W];
            len_v[i]   = rq_len[i*2 +: 2];
            wdata_v[i] = rq_wdata[i*RSA_DW +: RSA_DW];
        end
    end

    // Round-robin search starting one past the last winner.
    always_comb begin
        win_found = 1'b0;
        win_idx   = 2'd0;
        cand      = 2'd0;
        for (int k = 1; k <= 3; k++) begin
            cand = 2'((int'(last_gnt) + k) % 3);
            if (!win_found && rq_req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Main FSM: grant, beat sequencing and read drain.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state    <= IDLE;
            owner    <= 2'd0;
            last_gnt <= 2'd2;
            remain   <= 2'd0;
            wait_cnt <= 1'b0;
            bw       <= 1'b0;
            cur_addr <= '0;
            gnt_q    <= 3'b000;
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        owner    <= win_idx;
                        last_gnt <= win_idx;
                        gnt_q    <= 3'b001 << win_idx;
                        bw       <= rq_we[win_idx];
                        cur_addr <= addr_v[win_idx];
                        remain   <= len_v[win_idx];
                        state    <= BURST;
                    end
                end
                BURST: begin
                    cur_addr <= cur_addr + 1'b1;
                    if (remain == 2'd0) begin
                        if (bw) begin
                            gnt_q <= 3'b000;
                            state <= IDLE;
                        end else begin
                            wait_cnt <= 1'b1;
                            state    <= RD_WAIT;
                        end
                    end else begin
                        remain <= remain - 1'b1;
                    end
                end
                RD_WAIT: begin
                    if (wait_cnt == 1'b0) begin
                        gnt_q <= 3'b000;
                        state <= IDLE;
                    end else begin
                        wait_cnt <= 1'b0;
                    end
                end
                default: begin
                    gnt_q <= 3'b000;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Two-stage read return: beat -> BRAM latency -> registered word.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rd_pend    <= 1'b0;
            rd_pend_id <= 2'd0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
            rd_id      <= 2'd0;
        end else begin
            rd_pend    <= rd_beat;
            rd_pend_id <= owner;
            rd_valid   <= rd_pend;
            rd_data    <= rd_pend ? PLB_dout : '0;
            rd_id      <= rd_pend ? rd_pend_id : 2'd0;
        end
    end

    assign beat    = (state == BURST);
    assign wr_beat = beat & bw;
    assign rd_beat = beat & ~bw;

    assign PLB_en    = beat;
    assign PLB_we    = wr_beat;
    assign PLB_addr  = beat ? cur_addr : '0;
    assign PLB_din   = wr_beat ? wdata_v[owner] : '0;

    assign rq_gnt    = gnt_q;
    assign rq_wr_adv = wr_beat ? gnt_q : 3'b000;
    // Write bursts finish on the last beat; reads finish with the last return.
    assign rq_done   = ((wr_beat && remain == 2'd0) ||
                        (state == RD_WAIT && wait_cnt == 1'b0)) ? gnt_q : 3'b000;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_plb_arbiter.sv
// tb_plb_arbiter: table-driven bursts with a beat/read-return scoreboard,
// plus hand-written round-robin and reset-interruption sequences.
module tb_plb_arbiter;

    localparam int DW = 32;
    localparam int AW = 10;

    logic            clk = 1'b0;
    logic            sys_rst_n;
    logic [2:0]      rq_req;
    logic [2:0]      rq_we;
    logic [3*AW-1:0] rq_addr;
    logic [5:0]      rq_len;
    logic [3*DW-1:0] rq_wdata;
    logic [2:0]      rq_gnt;
    logic [2:0]      rq_wr_adv;
    logic [2:0]      rq_done;
    logic            rd_valid;
    logic [DW-1:0]   rd_data;
    logic [1:0]      rd_id;
    logic            PLB_en;
    logic            PLB_we;
    logic [AW-1:0]   PLB_addr;
    logic [DW-1:0]   PLB_din;
    logic [DW-1:0]   PLB_dout;
    logic            busy;

    plb_arbiter #(.RSA_DW(DW), .ADDR_W(AW)) dut (
        .clk(clk), .sys_rst_n(sys_rst_n),
        .rq_req(rq_req), .rq_we(rq_we), .rq_addr(rq_addr), .rq_len(rq_len),
        .rq_wdata(rq_wdata), .rq_gnt(rq_gnt), .rq_wr_adv(rq_wr_adv),
        .rq_done(rq_done), .rd_valid(rd_valid), .rd_data(rd_data), .rd_id(rd_id),
        .PLB_en(PLB_en), .PLB_we(PLB_we), .PLB_addr(PLB_addr), .PLB_din(PLB_din),
        .PLB_dout(PLB_dout), .busy(busy)
    );

    always #5 clk = ~clk;

    // BRAM model: registered read, data valid the cycle after the address.
    logic [DW-1:0] bram [1024];
    always @(posedge clk) begin
        if (PLB_en) begin
            if (PLB_we) bram[PLB_addr] <= PLB_din;
            PLB_dout <= bram[PLB_addr];
        end
    end

    typedef struct {
        logic [AW-1:0] addr;
        logic          we;
        logic [DW-1:0] din;
        logic [1:0]    id;
    } beat_t;

    typedef struct {
        logic [DW-1:0] data;
        logic [1:0]    id;
    } rdret_t;

    typedef struct {
        int            id;
        logic          we;
        logic [AW-1:0] addr;
        logic [1:0]    len;
        logic [DW-1:0] base;
        logic [DW-1:0] step;
        int            exp_done;
    } vec_t;

    beat_t   beat_q[$];
    rdret_t  rd_q[$];
    logic [DW-1:0] ref_mem [1024];
    vec_t    vecs [8];

    int   checks = 0;
    int   errors = 0;
    logic mon_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Scoreboard: every bus beat and every read return is popped and compared.
    always @(negedge clk) begin
        if (mon_en && sys_rst_n) begin
            if (PLB_en) begin
                if (beat_q.size() == 0) begin
                    chk("unexpected_beat", 64'(PLB_en), 64'd0);
                end else begin
                    beat_t eb;
                    eb = beat_q.pop_front();
                    chk("beat_addr", 64'(PLB_addr), 64'(eb.addr));
                    chk("beat_we", 64'(PLB_we), 64'(eb.we));
                    chk("beat_din", 64'(PLB_din), 64'(eb.din));
                    chk("beat_wr_adv", 64'(rq_wr_adv), eb.we ? 64'(3'b001 << eb.id) : 64'd0);
                end
            end else begin
                chk("idle_bus", {PLB_we, PLB_addr, PLB_din, rq_wr_adv}, 64'd0);
            end
            if (rd_valid) begin
                if (rd_q.size() == 0) begin
                    chk("unexpected_rd_valid", 64'(rd_valid), 64'd0);
                end else begin
                    rdret_t er;
                    er = rd_q.pop_front();
                    chk("rd_data", 64'(rd_data), 64'(er.data));
                    chk("rd_id", 64'(rd_id), 64'(er.id));
                end
            end
        end
    end

    task automatic run_txn(input vec_t v);
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [2:0]    oh;
        logic          adv;
        int            done_n;
        oh = 3'b001 << v.id;
        for (int k = 0; k <= int'(v.len); k++) begin
            a = v.addr + AW'(k);
            d = v.base + v.step * DW'(k);
            if (v.we) begin
                beat_q.push_back('{a, 1'b1, d, 2'(v.id)});
                ref_mem[a] = d;
            end else begin
                beat_q.push_back('{a, 1'b0, '0, 2'(v.id)});
                rd_q.push_back('{ref_mem[a], 2'(v.id)});
            end
        end
        rq_we[v.id]              = v.we;
        rq_addr[v.id*AW +: AW]   = v.addr;
        rq_len[v.id*2 +: 2]      = v.len;
        rq_wdata[v.id*DW +: DW]  = v.base;
        rq_req[v.id]             = 1'b1;
        @(posedge clk);
        #1;
        // Request withdrawn immediately; the burst must still run to completion.
        rq_req[v.id] = 1'b0;
        done_n = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (n == 1) begin
                chk("gnt_first_beat", 64'(rq_gnt), 64'(oh));
                chk("busy_in_burst", 64'(busy), 64'd1);
            end
            adv = rq_wr_adv[v.id];
            if (rq_done[v.id]) begin
                done_n = n;
                if (!v.we) chk("done_with_last_rd", 64'(rd_valid), 64'd1);
                break;
            end
            @(posedge clk);
            #1;
            if (adv) rq_wdata[v.id*DW +: DW] = rq_wdata[v.id*DW +: DW] + v.step;
        end
        chk("done_cycle", 64'(done_n), 64'(v.exp_done));
        @(negedge clk);
        chk("gnt_after_done", 64'(rq_gnt), 64'd0);
        chk("busy_after_done", 64'(busy), 64'd0);
        chk("done_one_cycle", 64'(rq_done), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int exp_order [5];
        int got;
        int gap;
        logic [2:0] prev;

        vecs[0] = '{0, 1'b1, 10'h010, 2'd3, 32'hA,  32'h1,  4};
        vecs[1] = '{1, 1'b1, 10'h3FE, 2'd3, 32'h100, 32'h1, 4};
        vecs[2] = '{2, 1'b1, 10'h020, 2'd1, 32'h11, 32'h11, 2};
        vecs[3] = '{2, 1'b0, 10'h020, 2'd1, 32'h0,  32'h0,  4};
        vecs[4] = '{0, 1'b0, 10'h010, 2'd3, 32'h0,  32'h0,  6};
        vecs[5] = '{1, 1'b0, 10'h3FE, 2'd3, 32'h0,  32'h0,  6};
        vecs[6] = '{0, 1'b1, 10'h050, 2'd0, 32'h55, 32'h1,  1};
        vecs[7] = '{1, 1'b0, 10'h050, 2'd0, 32'h0,  32'h0,  3};

        sys_rst_n = 1'b0;
        rq_req = '0; rq_we = '0; rq_addr = '0; rq_len = '0; rq_wdata = '0;
        #2;
        chk("reset_outputs", {PLB_en, PLB_we, PLB_addr, rq_gnt, rq_done, rq_wr_adv, rd_valid, busy}, 64'd0);
        #20;
        sys_rst_n = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;

        foreach (vecs[i]) run_txn(vecs[i]);
        chk("beat_q_drained", 64'(beat_q.size()), 64'd0);
        chk("rd_q_drained", 64'(rd_q.size()), 64'd0);
        mon_en = 1'b0;

        // Round-robin from reset with all three requesting single-word writes.
        sys_rst_n = 1'b0;
        rq_req = 3'b111; rq_we = 3'b111; rq_len = '0; rq_addr = '0;
        @(negedge clk);
        #2;
        sys_rst_n = 1'b1;
        exp_order = '{0, 1, 2, 0, 1};
        got = 0; gap = 0; prev = 3'b000;
        for (int c = 0; c < 40 && got < 5; c++) begin
            @(negedge clk);
            if (rq_gnt != 3'b000 && prev == 3'b000) begin
                chk("rr_grant", 64'(rq_gnt), 64'(3'b001 << exp_order[got]));
                if (got > 0) chk("rr_idle_gap", 64'(gap), 64'd1);
                got++;
                gap = 0;
            end else if (rq_gnt == 3'b000) begin
                gap++;
            end
            prev = rq_gnt;
        end
        chk("rr_grant_count", 64'(got), 64'd5);
        rq_req = 3'b000;
        repeat (4) @(negedge clk);

        // Read returns in flight at reset are discarded.
        rq_we[2] = 1'b0; rq_addr[2*AW +: AW] = 10'h020; rq_len[5:4] = 2'd1;
        rq_req[2] = 1'b1;
        @(posedge clk);
        #1;
        rq_req[2] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        sys_rst_n = 1'b0;
        @(negedge clk);
        chk("rst_rd_valid", 64'(rd_valid), 64'd0);
        #2;
        sys_rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rd_discarded", 64'(rd_valid), 64'd0);
        end

        // Reset at beat 2 of an rq0 write: outputs clear at once, no done, rq0 first after.
        rq_we = 3'b011; rq_addr[AW-1:0] = 10'h080; rq_len = 6'b000011;
        rq_req = 3'b001;
        @(posedge clk);
        #1;
        rq_req = 3'b000;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("beat2_addr", 64'(PLB_addr), 64'h082);
        #1;
        sys_rst_n = 1'b0;
        #1;
        chk("rst_mid_plb", {PLB_en, PLB_we, PLB_addr, PLB_din}, 64'd0);
        chk("rst_mid_ctrl", {rq_gnt, rq_done, rq_wr_adv, busy, rd_valid}, 64'd0);
        rq_len = 6'b000000;
        rq_req = 3'b011;
        @(negedge clk);
        chk("rst_no_done", 64'(rq_done), 64'd0);
        #2;
        sys_rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_first_grant", 64'(rq_gnt), 64'd1);
        rq_req = 3'b000;
        repeat (4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
